// File: rtl/clock_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clock_divider                                              |
// | Description : Divides clk_in by N = CLK_IN / CLK_OUT (integer division)  |
// |               into a registered square wave clk_out. The low phase is    |
// |               floor(N/2) cycles and the high phase is the rest, so odd   |
// |               ratios spend the extra cycle high.                         |
// | Ports       : clk_in  - reference clock, rising edge                     |
// |               rst     - synchronous reset, active low                    |
// |               clk_out - divided clock, driven straight from a flop       |
// |               tick    - one-cycle pulse on each clk_out rise (only when  |
// |                         CLOCK_DIVIDER_TICK_EN is defined)                |
// | Options     : `define CLOCK_DIVIDER_TICK_EN adds the tick output.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module clock_divider #(
  parameter int unsigned CLK_IN  = 200000000,
  parameter int unsigned CLK_OUT = 1000000
) (
  input  logic clk_in,
  input  logic rst,
`ifdef CLOCK_DIVIDER_TICK_EN
  output logic tick,
`endif
  output logic clk_out
);

  // Guard the division so a zero CLK_OUT reaches the elaboration check below
  // instead of failing as a divide-by-zero.
  localparam int unsigned N  = (CLK_OUT == 0) ? 0 : (CLK_IN / CLK_OUT);
  localparam int unsigned L  = N / 2;
  localparam int unsigned CW = (N <= 2) ? 1 : $clog2(N);

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_LOW  = CW'(L);

  if (CLK_OUT == 0) begin : g_err_zero_out
    $fatal(1, "clock_divider: CLK_OUT must be non-zero");
  end

  if (N < 2) begin : g_err_small_ratio
    $fatal(1, "clock_divider: CLK_IN / CLK_OUT must be at least 2");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == C_LAST) ? '0 : cnt + 1'b1;
  end

  // clk_out is decoded from the next count so it lands in the same flop
  // update as the counter; the port never sees a combinational term.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      clk_out <= (cnt_next >= C_LOW);
    end
  end

`ifdef CLOCK_DIVIDER_TICK_EN
  // Fires on exactly the count where clk_out goes from low to high.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      tick <= 1'b0;
    end else begin
      tick <= (cnt_next == C_LOW);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_clock_divider                                           |
// | Description : Self-checking bench for clock_divider. Four instances with |
// |               ratios 200, 7, 2 and 333 each get their own reset. The     |
// |               reference model says: on the k-th non-reset edge after     |
// |               release, clk_out is high iff (k mod N) >= floor(N/2), and  |
// |               tick is high iff (k mod N) == floor(N/2).                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_clock_divider;

  logic clk;
  logic rst_a, rst_b, rst_c, rst_d;
  logic out_a, out_b, out_c, out_d;
  logic tick_a, tick_b, tick_c, tick_d;

  int vectors;
  int miscompares;

  clock_divider #(.CLK_IN(200000000), .CLK_OUT(1000000)) u_div200 (
    .clk_in(clk), .rst(rst_a),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick(tick_a),
`endif
    .clk_out(out_a)
  );

  clock_divider #(.CLK_IN(7), .CLK_OUT(1)) u_div7 (
    .clk_in(clk), .rst(rst_b),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick(tick_b),
`endif
    .clk_out(out_b)
  );

  clock_divider #(.CLK_IN(2), .CLK_OUT(1)) u_div2 (
    .clk_in(clk), .rst(rst_c),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick(tick_c),
`endif
    .clk_out(out_c)
  );

  clock_divider #(.CLK_IN(1000), .CLK_OUT(3)) u_div333 (
    .clk_in(clk), .rst(rst_d),
`ifdef CLOCK_DIVIDER_TICK_EN
    .tick(tick_d),
`endif
    .clk_out(out_d)
  );

`ifndef CLOCK_DIVIDER_TICK_EN
  assign tick_a = 1'b0;
  assign tick_b = 1'b0;
  assign tick_c = 1'b0;
  assign tick_d = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected clk_out on the k-th edge after release (k = 0 means in reset).
  function automatic logic model_out(int k, int n);
    return (k % n) >= (n / 2);
  endfunction

  function automatic logic model_tick(int k, int n);
    return (k > 0) && ((k % n) == (n / 2));
  endfunction

  task automatic test_reset();
    int len = $urandom_range(3, 6);
    for (int i = 0; i < len; i++) begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({out_a, out_b, out_c, out_d} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_out: got %b expected 0000", {out_a, out_b, out_c, out_d});
      end
`ifdef CLOCK_DIVIDER_TICK_EN
      vectors++;
      if ({tick_a, tick_b, tick_c, tick_d} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_tick: got %b expected 0000", {tick_a, tick_b, tick_c, tick_d});
      end
`endif
    end
  endtask

  // N = 200: cycle-by-cycle model plus wall-clock rise spacing and duty.
  task automatic test_default_ratio();
    int  k = 0;
    int  cycles = 3 * 200 + $urandom_range(0, 199);
    int  rises = 0;
    int  highs = 0;
    logic prev = 1'b0;
    time last_rise = 0;
    for (int i = 0; i < cycles; i++) begin
      rst_a = 1'b1;
      @(posedge clk); #1;
      k++;
      vectors++;
      if (out_a !== model_out(k, 200)) begin
        miscompares++;
        $display("FAIL div200_out k=%0d: got %b expected %b", k, out_a, model_out(k, 200));
      end
`ifdef CLOCK_DIVIDER_TICK_EN
      vectors++;
      if (tick_a !== model_tick(k, 200)) begin
        miscompares++;
        $display("FAIL div200_tick k=%0d: got %b expected %b", k, tick_a, model_tick(k, 200));
      end
`endif
      if (k <= 400 && out_a === 1'b1) highs++;
      if (out_a === 1'b1 && prev === 1'b0) begin
        vectors++;
        if (rises == 0) begin
          if (k != 100) begin
            miscompares++;
            $display("FAIL div200_first_rise: got k=%0d expected k=100", k);
          end
        end else if (($time - last_rise) != 2000) begin
          miscompares++;
          $display("FAIL div200_period: got %0t expected 2000", $time - last_rise);
        end
        rises++;
        last_rise = $time;
      end
      prev = out_a;
    end
    vectors++;
    if (highs != 200) begin
      miscompares++;
      $display("FAIL div200_duty: got %0d high cycles expected 200 of 400", highs);
    end
    rst_a = 1'b0;
    @(posedge clk); #1;
  endtask

  // N = 200: reset pulses in the middle of a period, the first at k = 150
  // while clk_out is high, then random positions and lengths.
  task automatic test_reset_pulse();
    int k = 0;
    for (int seg = 0; seg < 5; seg++) begin
      int run = (seg == 0) ? 150 : (seg == 4) ? 260 : $urandom_range(1, 450);
      int len = (seg == 0) ? 1 : (seg == 4) ? 0 : $urandom_range(1, 3);
      for (int i = 0; i < run + len; i++) begin
        logic r = (i < run);
        rst_a = r;
        @(posedge clk); #1;
        k = r ? k + 1 : 0;
        vectors++;
        if (out_a !== model_out(k, 200)) begin
          miscompares++;
          $display("FAIL pulse_out seg=%0d k=%0d: got %b expected %b", seg, k, out_a, model_out(k, 200));
        end
`ifdef CLOCK_DIVIDER_TICK_EN
        vectors++;
        if (tick_a !== model_tick(k, 200)) begin
          miscompares++;
          $display("FAIL pulse_tick seg=%0d k=%0d: got %b expected %b", seg, k, tick_a, model_tick(k, 200));
        end
`endif
      end
    end
    rst_a = 1'b0;
    @(posedge clk); #1;
  endtask

  // N = 7: phase lengths of 3 low and 4 high after the short initial low.
  task automatic test_odd_ratio();
    int   k = 0;
    int   run = 0;
    int   phases = 0;
    logic prev = 1'b0;
    int   cycles = 5 * 7 + 7 + $urandom_range(0, 6);
    for (int i = 0; i < cycles; i++) begin
      rst_b = 1'b1;
      @(posedge clk); #1;
      k++;
      vectors++;
      if (out_b !== model_out(k, 7)) begin
        miscompares++;
        $display("FAIL div7_out k=%0d: got %b expected %b", k, out_b, model_out(k, 7));
      end
      if (out_b !== prev) begin
        if (phases > 0) begin
          vectors++;
          if (run != (prev ? 4 : 3)) begin
            miscompares++;
            $display("FAIL div7_phase: got %0d cycles expected %0d", run, prev ? 4 : 3);
          end
        end
        phases++;
        run = 0;
      end
      run++;
      prev = out_b;
    end
    rst_b = 1'b0;
    @(posedge clk); #1;
  endtask

  // N = 2: toggles every edge, high first at k = 1.
  task automatic test_min_ratio();
    int cycles = $urandom_range(16, 24);
    for (int k = 1; k <= cycles; k++) begin
      rst_c = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (out_c !== logic'(k % 2)) begin
        miscompares++;
        $display("FAIL div2_out k=%0d: got %b expected %b", k, out_c, logic'(k % 2));
      end
`ifdef CLOCK_DIVIDER_TICK_EN
      vectors++;
      if (tick_c !== logic'(k % 2)) begin
        miscompares++;
        $display("FAIL div2_tick k=%0d: got %b expected %b", k, tick_c, logic'(k % 2));
      end
`endif
    end
    rst_c = 1'b0;
    @(posedge clk); #1;
  endtask

  // N = 333 from a non-integer ratio: no drift over 10+ periods.
  task automatic test_non_integer();
    int   k = 0;
    int   last_k = 0;
    int   rises = 0;
    logic prev = 1'b0;
    int   cycles = 11 * 333 + $urandom_range(0, 332);
    for (int i = 0; i < cycles; i++) begin
      rst_d = 1'b1;
      @(posedge clk); #1;
      k++;
      vectors++;
      if (out_d !== model_out(k, 333)) begin
        miscompares++;
        $display("FAIL div333_out k=%0d: got %b expected %b", k, out_d, model_out(k, 333));
      end
      if (out_d === 1'b1 && prev === 1'b0) begin
        vectors++;
        if (k - last_k != ((rises == 0) ? 166 : 333)) begin
          miscompares++;
          $display("FAIL div333_rise_gap: got %0d expected %0d", k - last_k, (rises == 0) ? 166 : 333);
        end
        rises++;
        last_k = k;
      end
      prev = out_d;
    end
    vectors++;
    if (rises < 10) begin
      miscompares++;
      $display("FAIL div333_rise_count: got %0d expected at least 10", rises);
    end
    rst_d = 1'b0;
    @(posedge clk); #1;
  endtask

  // N = 7: short random released windows separated by random resets.
  task automatic test_back_to_back();
    int k = 0;
    for (int seg = 0; seg < 12; seg++) begin
      int run = $urandom_range(1, 16);
      int len = $urandom_range(1, 2);
      for (int i = 0; i < run + len; i++) begin
        logic r = (i < run);
        rst_b = r;
        @(posedge clk); #1;
        k = r ? k + 1 : 0;
        vectors++;
        if (out_b !== model_out(k, 7)) begin
          miscompares++;
          $display("FAIL b2b_out seg=%0d k=%0d: got %b expected %b", seg, k, out_b, model_out(k, 7));
        end
`ifdef CLOCK_DIVIDER_TICK_EN
        vectors++;
        if (tick_b !== model_tick(k, 7)) begin
          miscompares++;
          $display("FAIL b2b_tick seg=%0d k=%0d: got %b expected %b", seg, k, tick_b, model_tick(k, 7));
        end
`endif
      end
    end
    rst_b = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    test_reset();
    test_default_ratio();
    test_reset_pulse();
    test_odd_ratio();
    test_min_ratio();
    test_non_integer();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish within 2 ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
